// File: rtl/uart_frame_packer.sv
// uart_frame_packer: buffers 16-bit samples in a FIFO and sends them to uart_tx as framed bytes.
// A frame is AA 55 CHANNEL_ID seq, then each sample low byte first, then an 8-bit checksum.
// The checksum is the sum of CHANNEL_ID, seq and every sample byte.
// Ports:
//   i_clk, i_reset_n          clock and asynchronous active-low reset
//   i_sample_in/i_sample_valid sample write port; a write to a full FIFO is dropped and counted
//   i_tx_idle                 IDLE from uart_tx, assumed synchronous to i_clk
//   o_tx_wrreq/o_tx_wdata     byte write handshake to uart_tx
//   o_fifo_level              FIFO occupancy
//   o_overflow_cnt            saturating count of dropped samples
//   o_frame_done              one-cycle pulse once the checksum byte has been accepted
module uart_frame_packer #(
  parameter int unsigned FIFO_DEPTH        = 64,
  parameter int unsigned SAMPLES_PER_FRAME = 16,
  parameter logic [7:0]  CHANNEL_ID        = 8'h17
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [15:0]                   i_sample_in,
  input  logic                          i_sample_valid,
  input  logic                          i_tx_idle,
  output logic                          o_tx_wrreq,
  output logic [7:0]                    o_tx_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [15:0]                   o_overflow_cnt,
  output logic                          o_frame_done
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned NumBytes = 2 * SAMPLES_PER_FRAME + 5;
  localparam int unsigned IdxW     = $clog2(NumBytes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);
  localparam logic [AW:0]     Depth   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     Thresh  = (AW+1)'(SAMPLES_PER_FRAME);

  typedef enum logic [2:0] {StIdle, StLoad, StStrobe, StWaitBusy, StWaitDone} state_e;

  state_e            r_state, w_state_next;
  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_level;
  logic [15:0]       r_ovf;
  logic [IdxW-1:0]   r_byte_idx;
  logic [7:0]        r_seq, r_csum, r_wdata;
  logic              r_frame_done;

  logic [15:0]       w_head;
  logic [7:0]        w_cur_byte;
  logic              w_full, w_push, w_pop, w_byte_done, w_last, w_sample_hi;

  // ---------------- FIFO ----------------
  assign w_full = (r_level == Depth);
  // Fullness uses the pre-cycle level, so a push that meets a pop while full is still dropped.
  assign w_push = i_sample_valid && !w_full;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_sample_in;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
      if (i_sample_valid && w_full && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
    end
  end

  // ---------------- byte selection ----------------
  // Sample bytes start at index 4 (even), so bit 0 of the index selects the high byte.
  assign w_sample_hi = r_byte_idx[0] && (r_byte_idx > IdxW'(4)) && (r_byte_idx != LastIdx);

  always_comb begin
    w_cur_byte = r_byte_idx[0] ? w_head[15:8] : w_head[7:0];
    if (r_byte_idx == IdxW'(0))      w_cur_byte = 8'hAA;
    else if (r_byte_idx == IdxW'(1)) w_cur_byte = 8'h55;
    else if (r_byte_idx == IdxW'(2)) w_cur_byte = CHANNEL_ID;
    else if (r_byte_idx == IdxW'(3)) w_cur_byte = r_seq;
    else if (r_byte_idx == LastIdx)  w_cur_byte = r_csum;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (r_level >= Thresh) w_state_next = StLoad;
      StLoad:     w_state_next = StStrobe;
      StStrobe:   w_state_next = StWaitBusy;
      StWaitBusy: if (!i_tx_idle) w_state_next = StWaitDone;
      StWaitDone: if (i_tx_idle) w_state_next = (r_byte_idx == LastIdx) ? StIdle : StLoad;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_tx_wrreq  = (r_state == StStrobe);
    w_byte_done = (r_state == StWaitDone) && i_tx_idle;
    w_pop       = w_byte_done && w_sample_hi;
    w_last      = w_byte_done && (r_byte_idx == LastIdx);
    // The byte is shown combinationally in LOAD so it leads o_tx_wrreq by one cycle.
    o_tx_wdata  = (r_state == StLoad) ? w_cur_byte : r_wdata;
  end

  // ---------------- frame datapath ----------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_byte_idx   <= '0;
      r_seq        <= '0;
      r_csum       <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      unique case (r_state)
        StIdle: begin
          r_byte_idx <= '0;
          r_csum     <= '0;
        end
        StLoad: begin
          r_wdata <= w_cur_byte;
          // Sync bytes and the checksum itself are excluded from the sum.
          if (r_byte_idx >= IdxW'(2) && r_byte_idx != LastIdx) r_csum <= r_csum + w_cur_byte;
        end
        StWaitDone: begin
          if (w_last)           r_seq      <= r_seq + 8'd1;
          else if (w_byte_done) r_byte_idx <= r_byte_idx + IdxW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_level   = r_level;
  assign o_overflow_cnt = r_ovf;
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Self-checking bench for uart_frame_packer: a uart_tx model, directed stimulus, and a
// frame-level reference model compared against the DUT on every cycle.
module tb_uart_frame_packer;

  localparam int Depth = 64;
  localparam int Spf   = 16;
  localparam int LastK = 2 * Spf + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        tx_idle;
  logic        tx_wrreq;
  logic [7:0]  tx_wdata;
  logic [6:0]  fifo_level;
  logic [15:0] overflow_cnt;
  logic        frame_done;

  always #5 clk = ~clk;

  uart_frame_packer dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_sample_in    (sample_in),
    .i_sample_valid (sample_valid),
    .i_tx_idle      (tx_idle),
    .o_tx_wrreq     (tx_wrreq),
    .o_tx_wdata     (tx_wdata),
    .o_fifo_level   (fifo_level),
    .o_overflow_cnt (overflow_cnt),
    .o_frame_done   (frame_done)
  );

  // uart_tx model: busy for tb_busy cycles after each write, or 1000 on the stretched write.
  int   busy_cnt;
  int   tb_busy = 10;
  logic hold = 1'b0;
  int   g_wr = 0;
  int   stretch_at = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                busy_cnt <= 0;
    else if (tx_wrreq)         busy_cnt <= (g_wr + 1 == stretch_at) ? 1000 : tb_busy;
    else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
  end
  always @(posedge clk) if (tx_wrreq) g_wr <= g_wr + 1;
  assign tx_idle = !hold && (busy_cnt == 0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_q[$];
  int m_level, m_ovf, m_seq, m_k, prev_wdata, nf, n_done;
  bit m_in_frame, m_wait, m_seen_busy, m_done;
  int exp_b [0:LastK];
  int frame_seq [0:511];
  int first_bytes [0:LastK];

  initial begin
    nf = 0; n_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_wrreq", int'(tx_wrreq), 0);
        check("rst_wdata", int'(tx_wdata), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ovf", int'(overflow_cnt), 0);
        check("rst_done", int'(frame_done), 0);
        m_q.delete();
        m_level = 0; m_ovf = 0; m_seq = 0; m_k = 0; prev_wdata = 0;
        m_in_frame = 0; m_wait = 0; m_seen_busy = 0; m_done = 0;
      end else begin
        bit pop, last, push_ok;
        pop = 0; last = 0;
        check("level", int'(fifo_level), m_level);
        check("overflow_cnt", int'(overflow_cnt), m_ovf);
        check("frame_done", int'(frame_done), int'(m_done));
        if (frame_done) n_done++;
        check("wrreq_while_busy", int'(tx_wrreq && m_wait), 0);
        if (m_wait) begin
          check("wdata_hold", int'(tx_wdata), exp_b[m_k]);
          if (!tx_idle) m_seen_busy = 1;
          else if (m_seen_busy) begin
            m_wait = 0;
            if (m_k >= 5 && m_k < LastK && (m_k % 2) == 1) pop = 1;
            if (m_k == LastK) last = 1;
          end
        end
        if (tx_wrreq) begin
          if (!m_in_frame) begin
            int cs;
            nf++;
            m_in_frame = 1; m_k = 0;
            if (m_q.size() < Spf) check("frame_start_samples", m_q.size(), Spf);
            exp_b[0] = 'hAA; exp_b[1] = 'h55; exp_b[2] = 'h17; exp_b[3] = m_seq;
            cs = 'h17 + m_seq;
            for (int i = 0; i < Spf; i++) begin
              logic [15:0] s;
              s = (m_q.size() > 0) ? m_q.pop_front() : 16'h0;
              exp_b[4 + 2*i] = int'(s[7:0]);
              exp_b[5 + 2*i] = int'(s[15:8]);
              cs += int'(s[7:0]) + int'(s[15:8]);
            end
            exp_b[LastK] = cs % 256;
          end else begin
            m_k++;
          end
          check("byte", int'(tx_wdata), exp_b[m_k]);
          check("wdata_setup", prev_wdata, int'(tx_wdata));
          if (nf == 1) first_bytes[m_k] = int'(tx_wdata);
          if (m_k == 3 && nf < 512) frame_seq[nf] = int'(tx_wdata);
          m_wait = 1; m_seen_busy = 0;
        end
        push_ok = sample_valid && (m_level < Depth);
        if (sample_valid && !push_ok && m_ovf < 'hFFFF) m_ovf++;
        if (push_ok) m_q.push_back(sample_in);
        m_level = m_level + int'(push_ok) - int'(pop);
        if (last) begin
          m_in_frame = 0;
          m_seq = (m_seq + 1) % 256;
        end
        m_done = last;
        prev_wdata = int'(tx_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [15:0] d);
    sample_in = d; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (n_done < target && c < budget) begin tick(1); c++; end
    check("frame_done_wait", n_done, target);
  endtask

  initial begin
    int hdr [4];
    int base, c, e;
    hdr = '{'hAA, 'h55, 'h17, 'h00};
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single frame, slow uart_tx.
    for (int i = 0; i < Spf; i++) push(16'h0100 + 16'(i));
    check("lat_e0_wrreq", int'(tx_wrreq), 0);
    check("lat_e0_level", int'(fifo_level), 16);
    tick(1);
    check("lat_e1_wrreq", int'(tx_wrreq), 0);
    check("lat_e1_wdata", int'(tx_wdata), 'hAA);
    tick(1);
    check("lat_e2_wrreq", int'(tx_wrreq), 1);
    wait_done(1, 2000);
    tick(2);
    for (int k = 0; k <= LastK; k++) begin
      if (k < 4)           e = hdr[k];
      else if (k == LastK) e = 'h9F;
      else if (k % 2 == 0) e = (k - 4) / 2;
      else                 e = 1;
      check("frame1_byte", first_bytes[k], e);
    end
    check("frame1_done_count", n_done, 1);

    // Sequence wrap over 256 more back-to-back frames.
    tb_busy = 1;
    for (int i = 0; i < Spf; i++) push(16'($urandom));
    for (int f = 0; f < 256; f++) begin
      if (f < 255) for (int i = 0; i < Spf; i++) push(16'($urandom));
      wait_done(2 + f, 1000);
    end
    check("seq_frame256", frame_seq[256], 'hFF);
    check("seq_frame257", frame_seq[257], 'h00);

    // Overflow with uart_tx stalled, then a push while full that meets a pop.
    hold = 1'b1;
    tick(1);
    for (int i = 0; i < 70; i++) push(16'h2000 + 16'(i));
    check("ovf_level", int'(fifo_level), 64);
    check("ovf_count", int'(overflow_cnt), 6);
    sample_in = 16'h3000; sample_valid = 1'b1; hold = 1'b0;
    c = 0;
    while (fifo_level == 7'd64 && c < 2000) begin tick(1); c++; end
    sample_valid = 1'b0;
    check("pop_while_full_level", int'(fifo_level), 63);
    wait_done(261, 4000);
    tick(2);
    check("drain_level", int'(fifo_level), 0);

    // Handshake hold: byte 5 of the next frame keeps uart_tx busy for 1000 cycles.
    base = g_wr;
    stretch_at = g_wr + 5;
    for (int i = 0; i < Spf; i++) push(16'h6000 + 16'(i * 3));
    wait_done(262, 3000);
    check("stretch_byte_count", g_wr - base, LastK + 1);

    // Reset after byte 7 of a frame.
    base = g_wr;
    for (int i = 0; i < Spf; i++) push(16'h4000 + 16'(i));
    c = 0;
    while (g_wr < base + 7 && c < 2000) begin tick(1); c++; end
    check("reset_reach_byte7", g_wr - base, 7);
    rst_n = 1'b0;
    #1;
    check("midrst_wrreq", int'(tx_wrreq), 0);
    check("midrst_wdata", int'(tx_wdata), 0);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_ovf", int'(overflow_cnt), 0);
    check("midrst_done", int'(frame_done), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < Spf; i++) push(16'h5000 + 16'(i));
    wait_done(263, 3000);
    check("post_reset_seq", frame_seq[nf], 'h00);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
